uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 179 +++++++++++++++++
 tb/tb_uart_rx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, mid-bit sampling and sticky
// overrun / framing status cleared by a CPU read acknowledge.
`timescale 1ns/1ps

module uart_rx #(
    parameter int unsigned CLK_FREQ = 100000000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic       sysclk,
    input  logic       Reset_n,
    input  logic       UART_IN,
    input  logic       rd_ack,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       rx_overrun,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int unsigned DIV    = CLK_FREQ / (BAUD * 16);
    localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned TICK_W = 4;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned WARM_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                sync_1;
    logic                sync_2;
    logic                line_prev;
    logic [WARM_W-1:0]   warm;
    logic [DIV_W-1:0]    div_cnt;
    logic [TICK_W-1:0]   tick_cnt;
    logic [IDX_W-1:0]    bit_idx;
    logic [DATA_W-1:0]   shift_q;

    logic fall_c;
    logic tick_c;
    logic mid_start_c;
    logic mid_bit_c;
    logic shift_c;
    logic stop_good_c;
    logic stop_bad_c;
    logic tick_clr_c;

    // Synchronizer plus edge history; warm keeps the reset value of the
    // flops from masquerading as a falling edge when the line is already low.
    always_ff @(posedge sysclk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_1    <= 1'b1;
            sync_2    <= 1'b1;
            line_prev <= 1'b1;
            warm      <= '0;
        end else begin
            sync_1    <= UART_IN;
            sync_2    <= sync_1;
            line_prev <= sync_2;
            if (warm != WARM_W'(3)) begin
                warm <= warm + WARM_W'(1);
            end
        end
    end

    assign fall_c = (warm == WARM_W'(3)) && line_prev && !sync_2;
    assign tick_c = (state_q != ST_IDLE) && (div_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge sysclk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (fall_c)      state_d = ST_START;
            ST_START: if (mid_start_c) state_d = sync_2 ? ST_IDLE : ST_DATA;
            ST_DATA:  if (mid_bit_c && (bit_idx == IDX_W'(7))) state_d = ST_STOP;
            ST_STOP:  if (mid_bit_c)   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mid_start_c = 1'b0;
        mid_bit_c   = 1'b0;
        shift_c     = 1'b0;
        stop_good_c = 1'b0;
        stop_bad_c  = 1'b0;
        tick_clr_c  = 1'b0;
        case (state_q)
            ST_IDLE: tick_clr_c = 1'b1;
            ST_START: begin
                mid_start_c = tick_c && (tick_cnt == TICK_W'(7));
                tick_clr_c  = mid_start_c;
            end
            ST_DATA: begin
                mid_bit_c = tick_c && (tick_cnt == TICK_W'(15));
                shift_c   = mid_bit_c;
            end
            ST_STOP: begin
                mid_bit_c   = tick_c && (tick_cnt == TICK_W'(15));
                stop_good_c = mid_bit_c && sync_2;
                stop_bad_c  = mid_bit_c && !sync_2;
            end
            default: tick_clr_c = 1'b1;
        endcase
    end

    // Oversample divider, tick counter and bit index; all held at 0 in IDLE.
    always_ff @(posedge sysclk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shift_q  <= '0;
        end else begin
            if (state_q == ST_IDLE || div_cnt == DIV_W'(DIV - 1)) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            if (tick_clr_c) begin
                tick_cnt <= '0;
            end else if (tick_c) begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end

            if (state_q != ST_DATA) begin
                bit_idx <= '0;
            end else if (shift_c) begin
                bit_idx <= bit_idx + IDX_W'(1);
            end

            if (shift_c) begin
                shift_q <= {sync_2, shift_q[DATA_W-1:1]};
            end
        end
    end

    // Status: a completing frame takes priority over a coincident read ack.
    always_ff @(posedge sysclk or negedge Reset_n) begin
        if (!Reset_n) begin
            rx_data    <= '0;
            rx_ready   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            rx_busy    <= 1'b0;
        end else begin
            if (stop_good_c) begin
                rx_data    <= shift_q;
                rx_ready   <= 1'b1;
                rx_overrun <= rd_ack ? 1'b0 : (rx_overrun | rx_ready);
                frame_err  <= frame_err & ~rd_ack;
            end else if (stop_bad_c) begin
                frame_err  <= 1'b1;
                rx_ready   <= rx_ready & ~rd_ack;
                rx_overrun <= rx_overrun & ~rd_ack;
            end else if (rd_ack) begin
                rx_ready   <= 1'b0;
                rx_overrun <= 1'b0;
                frame_err  <= 1'b0;
            end
            rx_busy <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at DIV=10: directed vector table,
// multi-cycle corner sequences and randomized frames against a rule model.
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int BIT_CLKS = 160;

    logic       sysclk;
    logic       Reset_n;
    logic       UART_IN;
    logic       rd_ack;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_overrun;
    logic       frame_err;
    logic       rx_busy;

    int n_checks = 0;
    int n_pass   = 0;

    uart_rx #(.CLK_FREQ(1600000), .BAUD(10000)) dut (
        .sysclk     (sysclk),
        .Reset_n    (Reset_n),
        .UART_IN    (UART_IN),
        .rd_ack     (rd_ack),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .rx_overrun (rx_overrun),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit         send;
        bit         ack_before;
        logic [7:0] data;
        bit         stop_ok;
        logic [7:0] exp_data;
        bit         exp_ready;
        bit         exp_ovr;
        bit         exp_ferr;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, expv);
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d required %0d..%0d", name, act, lo, hi);
    endtask

    task automatic check_status(input string tag, input logic [7:0] d, input bit r,
                                input bit o, input bit f);
        check({tag, "_data"},    int'(rx_data),    int'(d));
        check({tag, "_ready"},   int'(rx_ready),   int'(r));
        check({tag, "_overrun"}, int'(rx_overrun), int'(o));
        check({tag, "_ferr"},    int'(frame_err),  int'(f));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic ack_pulse();
        @(posedge sysclk);
        #1 rd_ack = 1'b1;
        @(posedge sysclk);
        #1 rd_ack = 1'b0;
    endtask

    // Start bit driven just after the first edge; leaves the line idle high.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        logic [9:0] fr;
        fr = {stop_ok, b, 1'b0};
        @(posedge sysclk);
        #1;
        for (int i = 0; i < 10; i++) begin
            UART_IN = fr[i];
            repeat (BIT_CLKS) @(posedge sysclk);
            #1;
        end
        UART_IN = 1'b1;
    endtask

    int         busy_lat;
    int         lat;
    int         ack_at;
    logic [7:0] m_data;
    bit         m_ready;
    bit         m_ovr;
    bit         m_ferr;

    initial begin
        Reset_n = 1'b0;
        UART_IN = 1'b1;
        rd_ack  = 1'b0;

        vecs[0] = '{1'b1, 1'b1, 8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 8'hC3, 1'b1, 8'hC3, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 8'h55, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 8'h12, 1'b1, 8'h12, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 8'h99, 1'b0, 8'h12, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 8'hE7, 1'b1, 8'hE7, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'hE7, 1'b0, 1'b0, 1'b0};

        // Reset state
        idle(3);
        check_status("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        check("reset_busy", int'(rx_busy), 0);
        Reset_n = 1'b1;
        idle(10);

        // First frame: busy latency, frame length and received byte
        busy_lat = -1;
        lat      = -1;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                @(posedge sysclk);
                for (int n = 1; n <= 2000; n++) begin
                    @(posedge sysclk);
                    #1;
                    if (busy_lat < 0 && rx_busy) busy_lat = n;
                    if (rx_ready) begin
                        lat = n;
                        break;
                    end
                end
            end
        join
        idle(20);
        check_range("busy_rise_clocks", busy_lat, 1, 3);
        check_range("frame_clocks", lat, 1510, 1533);
        check_status("a5", 8'hA5, 1'b1, 1'b0, 1'b0);
        check("a5_busy", int'(rx_busy), 0);

        // Directed vector table
        foreach (vecs[i]) begin
            if (vecs[i].ack_before) begin
                ack_pulse();
                idle(2);
            end
            if (vecs[i].send) begin
                send_frame(vecs[i].data, vecs[i].stop_ok);
                idle(20);
            end
            check_status($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_ready,
                         vecs[i].exp_ovr, vecs[i].exp_ferr);
        end

        // Read ack landing on the stop-sample cycle while a byte is pending
        ack_at = (lat > 0) ? lat : 1523;
        send_frame(8'h42, 1'b1);
        idle(20);
        check("pre81_ready", int'(rx_ready), 1);
        fork
            send_frame(8'h81, 1'b1);
            begin
                @(posedge sysclk);
                repeat (ack_at - 1) @(posedge sysclk);
                #1 rd_ack = 1'b1;
                @(posedge sysclk);
                #1 rd_ack = 1'b0;
            end
        join
        idle(20);
        check_status("ack_coincide", 8'h81, 1'b1, 1'b0, 1'b0);

        // 40-clock low glitch on an idle line
        ack_pulse();
        idle(5);
        @(posedge sysclk);
        #1 UART_IN = 1'b0;
        idle(40);
        UART_IN = 1'b1;
        idle(10);
        check("glitch_busy_mid", int'(rx_busy), 1);
        idle(150);
        check("glitch_busy_end", int'(rx_busy), 0);
        check_status("glitch", 8'h81, 1'b0, 1'b0, 1'b0);

        // Reset during data bit 4; line stays low after release
        send_frame(8'h5A, 1'b1);
        idle(20);
        check("pre_reset_ready", int'(rx_ready), 1);
        fork
            send_frame(8'h0F, 1'b1);
            begin
                @(posedge sysclk);
                repeat (5 * BIT_CLKS + BIT_CLKS / 2) @(posedge sysclk);
                #1 Reset_n = 1'b0;
                #2;
                check_status("midreset", 8'h00, 1'b0, 1'b0, 1'b0);
                check("midreset_busy", int'(rx_busy), 0);
                repeat (3) @(posedge sysclk);
                #1 Reset_n = 1'b1;
            end
        join
        idle(40);
        check_status("after_abort", 8'h00, 1'b0, 1'b0, 1'b0);
        check("after_abort_busy", int'(rx_busy), 0);
        send_frame(8'h7E, 1'b1);
        idle(20);
        check_status("7e", 8'h7E, 1'b1, 1'b0, 1'b0);

        // Randomized frames against the status rule model
        m_data  = 8'h7E;
        m_ready = 1'b1;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            logic [7:0] b;
            bit         ok;
            bit         ackb;
            b    = 8'($urandom);
            ok   = ($urandom_range(0, 3) != 0);
            ackb = 1'($urandom_range(0, 1));
            if (ackb) begin
                ack_pulse();
                idle(2);
                m_ready = 1'b0;
                m_ovr   = 1'b0;
                m_ferr  = 1'b0;
            end
            send_frame(b, ok);
            idle(20);
            if (ok) begin
                if (m_ready) m_ovr = 1'b1;
                m_data  = b;
                m_ready = 1'b1;
            end else begin
                m_ferr = 1'b1;
            end
            check_status($sformatf("rand%0d", i), m_data, m_ready, m_ovr, m_ferr);
            check($sformatf("rand%0d_busy", i), int'(rx_busy), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
